// File: rtl/fv_req_dispatch.sv
// Feature-vector request dispatcher: maps PE node requests to FV banks, arbitrates
// round-robin per bank and issues one-cycle bank commands, holding each bank until its stream drains.
module fv_req_dispatch #(
  parameter int NUM_PE      = 4,
  parameter int NUM_BANK    = 2,
  parameter int NODE_W      = 8,
  parameter int BANK_ADDR_W = 10,
  parameter int MAX_FV_NUM  = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [$clog2(MAX_FV_NUM):0]           num_fv,
  input  logic [NUM_PE-1:0]                     pe_req_valid,
  input  logic [NUM_PE*NODE_W-1:0]              pe_req_node,
  output logic [NUM_PE-1:0]                     pe_req_ready,
  input  logic [NUM_BANK-1:0]                   bank_load_active,
  input  logic [NUM_BANK-1:0]                   bank_busy,
  output logic [NUM_BANK-1:0]                   cntl_valid,
  output logic [NUM_BANK*BANK_ADDR_W-1:0]       cntl_addr,
  output logic [NUM_BANK*$clog2(NUM_PE)-1:0]    cntl_pe_tag,
  output logic                                  idle
);

  localparam int FV_W       = $clog2(MAX_FV_NUM) + 1;
  localparam int PE_W       = $clog2(NUM_PE);
  localparam int BANK_W     = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int BANK_SHIFT = $clog2(NUM_BANK);
  localparam int PROD_W     = NODE_W + FV_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } bank_state_e;

  bank_state_e         state      [NUM_BANK];
  bank_state_e         state_nxt  [NUM_BANK];
  logic [FV_W-1:0]     hold_cnt     [NUM_BANK];
  logic [FV_W-1:0]     hold_cnt_nxt [NUM_BANK];
  logic [PE_W-1:0]     rr_ptr     [NUM_BANK];

  logic [NODE_W-1:0]   node       [NUM_PE];
  logic [BANK_W-1:0]   node_bank  [NUM_PE];
  logic [NODE_W-1:0]   node_row   [NUM_PE];

  logic [FV_W-1:0]     words;
  logic [FV_W-1:0]     hold_len;

  logic [NUM_BANK-1:0]    bank_idle;
  logic [NUM_BANK-1:0]    eligible;
  logic [NUM_BANK-1:0]    grant_any;
  logic [PE_W-1:0]        grant_idx  [NUM_BANK];
  logic [BANK_ADDR_W-1:0] grant_addr [NUM_BANK];

  // Node ID split: low bits pick the bank, the rest is the row inside that bank.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      node[i]      = pe_req_node[i*NODE_W +: NODE_W];
      node_bank[i] = (NUM_BANK > 1) ? node[i][BANK_W-1:0] : '0;
      node_row[i]  = node[i] >> BANK_SHIFT;
    end
  end

  // Two 8-bit elements per SRAM word; the stream occupies the bank for hold_len cycles.
  always_comb begin
    words = FV_W'(({1'b0, num_fv} + (FV_W+1)'(1)) >> 1);
    if (words == '0) words = FV_W'(1);
    hold_len = (num_fv < FV_W'(3)) ? FV_W'(1)
                                   : FV_W'({1'b0, num_fv[FV_W-1:1]} + FV_W'(1));
  end

  // Per-bank round-robin: first requester strictly after the pointer, with wrap.
  always_comb begin
    logic [PE_W-1:0]   idx;
    logic [PROD_W-1:0] prod;
    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    idx          = '0;
    prod         = '0;
    grant_any    = '0;
    pe_req_ready = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      grant_idx[b]  = '0;
      grant_addr[b] = '0;
      if (eligible[b]) begin
        for (int k = 1; k <= NUM_PE; k++) begin
          idx = PE_W'((int'(rr_ptr[b]) + k) % NUM_PE);
          if (!grant_any[b] && pe_req_valid[idx] && node_bank[idx] == BANK_W'(b)) begin
            grant_any[b] = 1'b1;
            grant_idx[b] = idx;
          end
        end
      end
      prod          = PROD_W'(node_row[grant_idx[b]]) * PROD_W'(words);
      grant_addr[b] = BANK_ADDR_W'(prod);
      if (grant_any[b]) pe_req_ready[grant_idx[b]] = 1'b1;
    end
  end

  // State register, hold counters, RR pointers and the registered command outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        state[b]    <= ST_IDLE;
        hold_cnt[b] <= '0;
        rr_ptr[b]   <= PE_W'(NUM_PE - 1);
      end
      cntl_valid  <= '0;
      cntl_addr   <= '0;
      cntl_pe_tag <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        state[b]      <= state_nxt[b];
        hold_cnt[b]   <= hold_cnt_nxt[b];
        cntl_valid[b] <= grant_any[b];
        if (grant_any[b]) begin
          rr_ptr[b]                                  <= grant_idx[b];
          cntl_addr[b*BANK_ADDR_W +: BANK_ADDR_W]    <= grant_addr[b];
          cntl_pe_tag[b*PE_W +: PE_W]                <= grant_idx[b];
        end
      end
    end
  end

  // Next state: the hold length is captured at grant, so later num_fv changes do not matter.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      state_nxt[b]    = state[b];
      hold_cnt_nxt[b] = hold_cnt[b];
      unique case (state[b])
        ST_IDLE: begin
          if (grant_any[b]) begin
            state_nxt[b]    = ST_HOLD;
            hold_cnt_nxt[b] = hold_len;
          end
        end
        ST_HOLD: begin
          if (hold_cnt[b] <= FV_W'(1)) begin
            state_nxt[b]    = ST_IDLE;
            hold_cnt_nxt[b] = '0;
          end else begin
            hold_cnt_nxt[b] = hold_cnt[b] - FV_W'(1);
          end
        end
        default: begin
          state_nxt[b]    = ST_IDLE;
          hold_cnt_nxt[b] = '0;
        end
      endcase
    end
  end

  // State-decoded outputs; reset suppresses grants so nothing transfers while it is high.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      bank_idle[b] = (state[b] == ST_IDLE);
    end
    eligible = bank_idle & ~bank_load_active & ~bank_busy & {NUM_BANK{~reset}};
    idle     = (&bank_idle) & ~(|pe_req_valid);
  end

endmodule

// File: tb/tb_fv_req_dispatch.sv
// Self-checking bench for fv_req_dispatch: directed scenarios plus a randomized run
// checked against a timestamp-based reference model of the dispatch rules.
module tb_fv_req_dispatch;

  localparam int NUM_PE      = 4;
  localparam int NUM_BANK    = 2;
  localparam int NODE_W      = 8;
  localparam int BANK_ADDR_W = 10;
  localparam int MAX_FV_NUM  = 16;
  localparam int FV_W        = 5;
  localparam int PE_W        = 2;

  logic                            clk = 1'b0;
  logic                            reset;
  logic [FV_W-1:0]                 num_fv;
  logic [NUM_PE-1:0]               pe_req_valid;
  logic [NUM_PE*NODE_W-1:0]        pe_req_node;
  logic [NUM_PE-1:0]               pe_req_ready;
  logic [NUM_BANK-1:0]             bank_load_active;
  logic [NUM_BANK-1:0]             bank_busy;
  logic [NUM_BANK-1:0]             cntl_valid;
  logic [NUM_BANK*BANK_ADDR_W-1:0] cntl_addr;
  logic [NUM_BANK*PE_W-1:0]        cntl_pe_tag;
  logic                            idle;

  int n_checks = 0;
  int n_pass   = 0;

  fv_req_dispatch #(
    .NUM_PE(NUM_PE), .NUM_BANK(NUM_BANK), .NODE_W(NODE_W),
    .BANK_ADDR_W(BANK_ADDR_W), .MAX_FV_NUM(MAX_FV_NUM)
  ) dut (
    .clk(clk), .reset(reset), .num_fv(num_fv),
    .pe_req_valid(pe_req_valid), .pe_req_node(pe_req_node), .pe_req_ready(pe_req_ready),
    .bank_load_active(bank_load_active), .bank_busy(bank_busy),
    .cntl_valid(cntl_valid), .cntl_addr(cntl_addr), .cntl_pe_tag(cntl_pe_tag),
    .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [BANK_ADDR_W-1:0] addr_of(input int b);
    return cntl_addr[b*BANK_ADDR_W +: BANK_ADDR_W];
  endfunction

  function automatic logic [PE_W-1:0] tag_of(input int b);
    return cntl_pe_tag[b*PE_W +: PE_W];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int pe, input int node);
    pe_req_valid[pe]                   = 1'b1;
    pe_req_node[pe*NODE_W +: NODE_W]   = NODE_W'(node);
  endtask

  task automatic apply_reset;
    reset            = 1'b1;
    pe_req_valid     = '0;
    pe_req_node      = '0;
    bank_load_active = '0;
    bank_busy        = '0;
    step;
    step;
    reset            = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_req(0, 0);
    #1;
    n_checks++; if (pe_req_ready !== 4'b0000) $display("FAIL reset_ready_in_reset got=%b exp=0000", pe_req_ready); else n_pass++;
    n_checks++; if (idle !== 1'b0) $display("FAIL reset_idle_with_req got=%b exp=0", idle); else n_pass++;
    apply_reset;
    n_checks++; if (cntl_valid !== 2'b00) $display("FAIL reset_valid got=%b exp=00", cntl_valid); else n_pass++;
    n_checks++; if (cntl_addr !== '0) $display("FAIL reset_addr got=%h exp=0", cntl_addr); else n_pass++;
    n_checks++; if (cntl_pe_tag !== '0) $display("FAIL reset_tag got=%h exp=0", cntl_pe_tag); else n_pass++;
    #1;
    n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", idle); else n_pass++;
  endtask

  task automatic test_single;
    apply_reset;
    num_fv = 5'd8;
    set_req(2, 5);
    #1;
    n_checks++; if (pe_req_ready !== 4'b0100) $display("FAIL single_ready got=%b exp=0100", pe_req_ready); else n_pass++;
    step;
    n_checks++; if (cntl_valid !== 2'b10) $display("FAIL single_valid got=%b exp=10", cntl_valid); else n_pass++;
    n_checks++; if (addr_of(1) !== 10'd8) $display("FAIL single_addr got=%0d exp=8", addr_of(1)); else n_pass++;
    n_checks++; if (tag_of(1) !== 2'd2) $display("FAIL single_tag got=%0d exp=2", tag_of(1)); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (pe_req_ready !== 4'b0000) $display("FAIL single_hold_ready k=%0d got=%b exp=0000", k, pe_req_ready); else n_pass++;
      step;
      n_checks++; if (cntl_valid !== 2'b00) $display("FAIL single_hold_valid k=%0d got=%b exp=00", k, cntl_valid); else n_pass++;
    end
    #1;
    n_checks++; if (pe_req_ready !== 4'b0100) $display("FAIL single_regrant_ready got=%b exp=0100", pe_req_ready); else n_pass++;
    step;
    pe_req_valid = '0;
    n_checks++; if (cntl_valid !== 2'b10) $display("FAIL single_regrant_valid got=%b exp=10", cntl_valid); else n_pass++;
  endtask

  task automatic test_round_robin;
    apply_reset;
    num_fv = 5'd2;
    set_req(0, 0);
    set_req(1, 2);
    #1;
    n_checks++; if (pe_req_ready !== 4'b0001) $display("FAIL rr_first_ready got=%b exp=0001", pe_req_ready); else n_pass++;
    step;
    n_checks++; if (cntl_valid !== 2'b01) $display("FAIL rr_first_valid got=%b exp=01", cntl_valid); else n_pass++;
    n_checks++; if (addr_of(0) !== 10'd0 || tag_of(0) !== 2'd0) $display("FAIL rr_first_cmd got=%0d/%0d exp=0/0", addr_of(0), tag_of(0)); else n_pass++;
    #1;
    n_checks++; if (pe_req_ready !== 4'b0000) $display("FAIL rr_hold_ready got=%b exp=0000", pe_req_ready); else n_pass++;
    step;
    n_checks++; if (cntl_valid !== 2'b00) $display("FAIL rr_gap_valid got=%b exp=00", cntl_valid); else n_pass++;
    #1;
    n_checks++; if (pe_req_ready !== 4'b0010) $display("FAIL rr_second_ready got=%b exp=0010", pe_req_ready); else n_pass++;
    step;
    pe_req_valid[1] = 1'b0;
    n_checks++; if (cntl_valid !== 2'b01) $display("FAIL rr_second_valid got=%b exp=01", cntl_valid); else n_pass++;
    n_checks++; if (addr_of(0) !== 10'd1 || tag_of(0) !== 2'd1) $display("FAIL rr_second_cmd got=%0d/%0d exp=1/1", addr_of(0), tag_of(0)); else n_pass++;
    step;
    #1;
    n_checks++; if (pe_req_ready !== 4'b0001) $display("FAIL rr_third_ready got=%b exp=0001", pe_req_ready); else n_pass++;
    step;
    pe_req_valid = '0;
    n_checks++; if (cntl_valid !== 2'b01 || tag_of(0) !== 2'd0) $display("FAIL rr_third_cmd got=%b/%0d exp=01/0", cntl_valid, tag_of(0)); else n_pass++;
  endtask

  task automatic test_parallel;
    apply_reset;
    num_fv = 5'd4;
    set_req(0, 0);
    set_req(1, 1);
    #1;
    n_checks++; if (pe_req_ready !== 4'b0011) $display("FAIL par_ready got=%b exp=0011", pe_req_ready); else n_pass++;
    step;
    pe_req_valid = '0;
    n_checks++; if (cntl_valid !== 2'b11) $display("FAIL par_valid got=%b exp=11", cntl_valid); else n_pass++;
    n_checks++; if (tag_of(0) !== 2'd0 || tag_of(1) !== 2'd1) $display("FAIL par_tags got=%0d,%0d exp=0,1", tag_of(0), tag_of(1)); else n_pass++;
    n_checks++; if (addr_of(0) !== 10'd0 || addr_of(1) !== 10'd0) $display("FAIL par_addr got=%0d,%0d exp=0,0", addr_of(0), addr_of(1)); else n_pass++;
  endtask

  task automatic test_load_block;
    apply_reset;
    num_fv           = 5'd6;
    bank_load_active = 2'b01;
    set_req(3, 4);
    set_req(1, 3);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (pe_req_ready !== ((k == 0) ? 4'b0010 : 4'b0000)) $display("FAIL load_ready k=%0d got=%b", k, pe_req_ready); else n_pass++;
      step;
      pe_req_valid[1] = 1'b0;
      n_checks++; if (cntl_valid !== ((k == 0) ? 2'b10 : 2'b00)) $display("FAIL load_valid k=%0d got=%b", k, cntl_valid); else n_pass++;
      if (k == 0) begin
        n_checks++; if (addr_of(1) !== 10'd3 || tag_of(1) !== 2'd1) $display("FAIL load_other_bank got=%0d/%0d exp=3/1", addr_of(1), tag_of(1)); else n_pass++;
      end
    end
    bank_load_active = 2'b00;
    #1;
    n_checks++; if (pe_req_ready !== 4'b1000) $display("FAIL load_release_ready got=%b exp=1000", pe_req_ready); else n_pass++;
    step;
    pe_req_valid = '0;
    n_checks++; if (cntl_valid !== 2'b01) $display("FAIL load_release_valid got=%b exp=01", cntl_valid); else n_pass++;
    n_checks++; if (addr_of(0) !== 10'd6 || tag_of(0) !== 2'd3) $display("FAIL load_release_cmd got=%0d/%0d exp=6/3", addr_of(0), tag_of(0)); else n_pass++;
  endtask

  task automatic test_hold_num_fv_change;
    apply_reset;
    num_fv = 5'd7;
    set_req(0, 0);
    #1;
    n_checks++; if (pe_req_ready !== 4'b0001) $display("FAIL hold_ready got=%b exp=0001", pe_req_ready); else n_pass++;
    step;
    num_fv = 5'd1;
    set_req(0, 2);
    n_checks++; if (cntl_valid !== 2'b01) $display("FAIL hold_valid got=%b exp=01", cntl_valid); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (pe_req_ready !== 4'b0000) $display("FAIL hold_block k=%0d got=%b exp=0000", k, pe_req_ready); else n_pass++;
      step;
    end
    #1;
    n_checks++; if (pe_req_ready !== 4'b0001) $display("FAIL hold_release_ready got=%b exp=0001", pe_req_ready); else n_pass++;
    step;
    pe_req_valid = '0;
    n_checks++; if (cntl_valid !== 2'b01 || addr_of(0) !== 10'd1) $display("FAIL hold_release_cmd got=%b/%0d exp=01/1", cntl_valid, addr_of(0)); else n_pass++;
  endtask

  task automatic test_reset_mid;
    apply_reset;
    num_fv = 5'd7;
    set_req(1, 2);
    #1;
    n_checks++; if (pe_req_ready !== 4'b0010) $display("FAIL rmid_ready got=%b exp=0010", pe_req_ready); else n_pass++;
    step;
    pe_req_valid = '0;
    n_checks++; if (cntl_valid !== 2'b01 || addr_of(0) !== 10'd4 || tag_of(0) !== 2'd1) $display("FAIL rmid_cmd got=%b/%0d/%0d exp=01/4/1", cntl_valid, addr_of(0), tag_of(0)); else n_pass++;
    step;
    reset = 1'b1;
    set_req(2, 4);
    #1;
    n_checks++; if (pe_req_ready !== 4'b0000) $display("FAIL rmid_ready_in_reset got=%b exp=0000", pe_req_ready); else n_pass++;
    step;
    reset = 1'b0;
    n_checks++; if (cntl_valid !== 2'b00 || cntl_addr !== '0 || cntl_pe_tag !== '0) $display("FAIL rmid_outputs got=%b/%h/%h exp=0", cntl_valid, cntl_addr, cntl_pe_tag); else n_pass++;
    #1;
    n_checks++; if (pe_req_ready !== 4'b0100) $display("FAIL rmid_after_ready got=%b exp=0100", pe_req_ready); else n_pass++;
    step;
    pe_req_valid = '0;
    n_checks++; if (cntl_valid !== 2'b01 || addr_of(0) !== 10'd8 || tag_of(0) !== 2'd2) $display("FAIL rmid_after_cmd got=%b/%0d/%0d exp=01/8/2", cntl_valid, addr_of(0), tag_of(0)); else n_pass++;
  endtask

  // Reference model: each bank is free from a cycle number onwards; a grant at cycle g
  // with stream length S makes it free again at g+1+S.
  task automatic test_random;
    logic              pend     [NUM_PE];
    logic [NODE_W-1:0] pnode    [NUM_PE];
    int                free_at  [NUM_BANK];
    int                ptr      [NUM_BANK];
    logic              exp_v    [NUM_BANK];
    int                exp_addr [NUM_BANK];
    int                exp_tag  [NUM_BANK];
    logic [NUM_PE-1:0] exp_ready;
    logic              exp_idle;
    logic              found;
    int                words, s, pe;
    apply_reset;
    for (int i = 0; i < NUM_PE; i++) begin
      pend[i]  = 1'b0;
      pnode[i] = '0;
    end
    for (int b = 0; b < NUM_BANK; b++) begin
      free_at[b] = 0; ptr[b] = NUM_PE - 1; exp_v[b] = 1'b0; exp_addr[b] = 0; exp_tag[b] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        n_checks++; if (cntl_valid[b] !== exp_v[b]) $display("FAIL rand_valid cyc=%0d bank=%0d got=%b exp=%b", cyc, b, cntl_valid[b], exp_v[b]); else n_pass++;
        if (exp_v[b]) begin
          n_checks++; if (int'(addr_of(b)) != exp_addr[b] || int'(tag_of(b)) != exp_tag[b]) $display("FAIL rand_cmd cyc=%0d bank=%0d got=%0d/%0d exp=%0d/%0d", cyc, b, addr_of(b), tag_of(b), exp_addr[b], exp_tag[b]); else n_pass++;
        end
      end
      for (int i = 0; i < NUM_PE; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          pnode[i] = NODE_W'($urandom);
        end
        pe_req_valid[i]                 = pend[i];
        pe_req_node[i*NODE_W +: NODE_W] = pnode[i];
      end
      num_fv = FV_W'($urandom_range(1, MAX_FV_NUM));
      for (int b = 0; b < NUM_BANK; b++) begin
        bank_load_active[b] = ($urandom_range(0, 5) == 0);
        bank_busy[b]        = ($urandom_range(0, 5) == 0);
      end
      #1;
      words    = (int'(num_fv) + 1) / 2;
      s        = (num_fv < 3) ? 1 : int'(num_fv) / 2 + 1;
      exp_idle = 1'b1;
      for (int i = 0; i < NUM_PE; i++) if (pend[i]) exp_idle = 1'b0;
      for (int b = 0; b < NUM_BANK; b++) if (cyc < free_at[b]) exp_idle = 1'b0;
      exp_ready = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
        exp_v[b] = 1'b0;
        found    = 1'b0;
        if (cyc >= free_at[b] && !bank_load_active[b] && !bank_busy[b]) begin
          for (int k = 1; k <= NUM_PE; k++) begin
            pe = (ptr[b] + k) % NUM_PE;
            if (!found && pend[pe] && (int'(pnode[pe]) % NUM_BANK) == b) begin
              found         = 1'b1;
              exp_ready[pe] = 1'b1;
              exp_v[b]      = 1'b1;
              exp_addr[b]   = ((int'(pnode[pe]) / NUM_BANK) * words) % (1 << BANK_ADDR_W);
              exp_tag[b]    = pe;
              ptr[b]        = pe;
              free_at[b]    = cyc + 1 + s;
              pend[pe]      = 1'b0;
            end
          end
        end
      end
      n_checks++; if (pe_req_ready !== exp_ready) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, pe_req_ready, exp_ready); else n_pass++;
      n_checks++; if (idle !== exp_idle) $display("FAIL rand_idle cyc=%0d got=%b exp=%b", cyc, idle, exp_idle); else n_pass++;
      step;
    end
    pe_req_valid     = '0;
    bank_load_active = '0;
    bank_busy        = '0;
  endtask

  initial begin
    reset            = 1'b1;
    num_fv           = 5'd8;
    pe_req_valid     = '0;
    pe_req_node      = '0;
    bank_load_active = '0;
    bank_busy        = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_parallel;
    test_load_block;
    test_hold_num_fv_change;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fv_req_dispatch.md
Name: fv_req_dispatch

Overview:
- Upstream neighbour of the per-bank FV bank controllers; accepts feature-vector fetch requests from NUM_PE Edge PEs.
- Maps each requested node ID to a bank and a base word address.
- Arbitrates round-robin per bank and issues one-cycle {valid, FV_Bank_addr, PE_tag} commands.
- Holds each bank off until its previous stream has fully drained.

Parameters:
- NUM_PE, 4, number of requesting Edge PEs.
- NUM_BANK, 2, number of FV banks (power of 2).
- NODE_W, 8, node ID width.
- BANK_ADDR_W, 10, bank SRAM word address width.
- MAX_FV_NUM, 16, maximum FV length in 8-bit elements.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- num_fv  in  clog2(MAX_FV_NUM)+1  FV length in 8-bit elements (1..MAX_FV_NUM).
- pe_req_valid  in  NUM_PE  per-PE request valid.
- pe_req_node  in  NUM_PE*NODE_W  per-PE node ID, PE i at bits [i*NODE_W +: NODE_W].
- pe_req_ready  out  NUM_PE  per-PE accept, combinational.
- bank_load_active  in  NUM_BANK  bank is being written by the FV loader (sos..eos window).
- bank_busy  in  NUM_BANK  bank controller Busy.
- cntl_valid  out  NUM_BANK  command valid per bank.
- cntl_addr  out  NUM_BANK*BANK_ADDR_W  base word address per bank.
- cntl_pe_tag  out  NUM_BANK*clog2(NUM_PE)  requesting PE per bank.
- idle  out  1  all banks in IDLE and no pe_req_valid asserted.

Behaviour:
- Reset values: cntl_valid=0, cntl_addr=0, cntl_pe_tag=0, all bank FSMs IDLE, hold counters 0, RR pointers = NUM_PE-1 (PE0 wins first).
- Mapping:
  - bank = node[clog2(NUM_BANK)-1:0].
  - row = node >> clog2(NUM_BANK).
  - words = (num_fv+1)>>1, forced to 1 if 0.
  - addr = row*words, truncated to BANK_ADDR_W.
- Stream length per command:
  - S = 1 if num_fv<3.
  - S = (num_fv>>1)+1 otherwise.
- Per-bank FSM states: IDLE, HOLD.
- Bank b is eligible in a cycle when it is in IDLE, bank_load_active[b]=0 and bank_busy[b]=0.
- Arbitration, per eligible bank:
  - Candidates are PEs with pe_req_valid=1 that map to b.
  - Grant the first candidate strictly after RR pointer b, with wrap-around; the pointer then becomes the granted PE.
  - A PE maps to exactly one bank, so banks grant independently and the same cycle can see grants on several banks.
- Handshake:
  - pe_req_ready[i]=1 only in the cycle PE i is granted; transfer occurs on valid&ready.
  - A PE holds valid and node stable until ready; a non-granted PE keeps waiting with no timeout.
- Issue:
  - A grant in cycle t registers cntl_valid[b]=1, cntl_addr[b], cntl_pe_tag[b] at edge t+1; cntl_valid is a 1-cycle pulse.
  - cntl_addr and cntl_pe_tag hold their last value after the pulse.
  - The FSM enters HOLD with counter=S, computed from num_fv sampled at grant.
- HOLD:
  - Counter decrements each cycle; at 0 the FSM returns to IDLE.
  - Net effect: after a pulse at cycle t, the next pulse on the same bank is no earlier than cycle t+1+S.
  - num_fv changes during HOLD do not affect the running count.
- bank_load_active or bank_busy high in IDLE blocks grants to that bank only; other banks continue.
- Simultaneous events: a request arriving in the cycle the bank returns to IDLE is grantable in that same cycle.
- Reset mid-operation: all in-flight holds and pending arbitration are discarded; no pulse in the cycle after reset.
- idle is combinational.

Test Plan:
- Reset, num_fv=8, PE2 requests node 5 (bank1, row2): ready[2] in the request cycle; next cycle cntl_valid[1]=1, addr=8, tag=2; no second pulse on bank1 for the following 5 cycles.
- num_fv=2, PE0 node 0 and PE1 node 2 (both bank0) held continuously:
  - bank0 grants PE0 first, then PE1; pulses 2 cycles apart.
  - addr 0 then 1.
- PE0 node 0 (bank0) and PE1 node 1 (bank1) in the same cycle: both ready; both banks pulse in the same cycle, tags 0 and 1, addr 0.
- bank_load_active[0]=1 for 4 cycles while PE3 requests node 4: no ready and no pulse until release; pulse one cycle after release with addr=2*words.
- num_fv=7 (S=4), num_fv switched to 1 during HOLD: bank still blocks 4 cycles.
- num_fv=7 (S=4), reset asserted during HOLD: outputs 0; a new request is granted in the first cycle after reset.
